// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a show-ahead byte FIFO: start, 8 data LSB first, optional parity, 1-2 stop bits.
// Latency: start bit appears on tx the cycle after the pop; frame lasts (9+PARITY_EN+STOP_BITS) x N clocks.
// Backpressure: pops only when idle or on the last stop cycle with tx_enable high and FIFO non-empty; frames never stall.
module fifo_uart_tx #(
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        tx_enable,
    input  logic [15:0] baud_div,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        fifo_read_enable,
    output logic        tx,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [3:0] LAST_STOP  = 4'(STOP_BITS - 1);
    localparam logic       HAS_PARITY = (PARITY_EN != 0);
    localparam logic       ODD_PARITY = (PARITY_ODD != 0);

    state_t      state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic [15:0] div_q, div_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]  bit_idx_q, bit_idx_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        launch;
    logic        pop;
    logic        bit_end;

    // Next-state logic: bit sequencing plus the launch/pop decision shared by idle and end-of-frame.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        par_d      = par_q;
        div_d      = div_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        tx_d       = tx_q;

        // A pop is only requested where a new frame may legally start; done_q marks the
        // final stop cycle, which lets the next start bit follow with no idle gap.
        // Gating with reset_n keeps a byte from being popped and then thrown away.
        launch  = tx_enable & ~fifo_empty;
        pop     = reset_n & launch & ((state_q == S_IDLE) | done_q);
        bit_end = (baud_cnt_q == (div_q - 16'd1));

        if (state_q != S_IDLE) begin
            baud_cnt_d = bit_end ? 16'd0 : (baud_cnt_q + 16'd1);
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = 4'd0;
                    tx_d      = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 4'd7) begin
                        bit_idx_d = 4'd0;
                        if (HAS_PARITY) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        // Current data bit always sits in shift_q[0].
                        bit_idx_d = bit_idx_q + 4'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d   = S_STOP;
                    bit_idx_d = 4'd0;
                    tx_d      = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_idx_q == LAST_STOP) begin
                        state_d   = S_IDLE;
                        bit_idx_d = 4'd0;
                        tx_d      = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Launch overrides the end-of-frame return to idle; the byte, divisor and parity
        // are frozen here so later input changes cannot disturb the frame.
        if (pop) begin
            state_d    = S_START;
            shift_d    = fifo_data;
            par_d      = (^fifo_data) ^ ODD_PARITY;
            div_d      = (baud_div == 16'd0) ? 16'd1 : baud_div;
            baud_cnt_d = 16'd0;
            bit_idx_d  = 4'd0;
            tx_d       = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_STOP) && (bit_idx_d == LAST_STOP) &&
                 (baud_cnt_d == (div_d - 16'd1));
    end

    // State and registered outputs; synchronous reset aborts any frame in flight.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            shift_q    <= 8'd0;
            par_q      <= 1'b0;
            div_q      <= 16'd0;
            baud_cnt_q <= 16'd0;
            bit_idx_q  <= 4'd0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            div_q      <= div_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign fifo_read_enable = pop;
    assign tx               = tx_q;
    assign busy             = busy_q;
    assign frame_done       = done_q;

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Serial transmit stage directly downstream of the 32-entry byte FIFO buffer.
- Drains bytes from the FIFO read side and sends each one as an asynchronous UART frame: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Pops at most one byte per frame. Frames go back-to-back with no idle gap while data is available.

Parameters:
- PARITY_EN, 0, 1 = append a parity bit after the data bits.
- PARITY_ODD, 0, when PARITY_EN=1: 1 = odd parity, 0 = even parity.
- STOP_BITS, 1, number of stop bits; legal values are 1 and 2.

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- tx_enable  input  1  permits starting new frames; a frame in progress always completes.
- baud_div  input  16  clocks per serial bit; sampled once per frame.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  8  FIFO head byte; show-ahead, valid whenever fifo_empty=0.
- fifo_read_enable  output  1  one-cycle pop request to the FIFO.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is on the line.
- frame_done  output  1  one-cycle pulse on the final cycle of each frame's last stop bit.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - Values: tx=1, busy=0, frame_done=0, fifo_read_enable=0, state=IDLE, bit and baud counters cleared.
  - Mid-frame reset aborts the frame immediately: tx returns to 1 at the next edge and no pop occurs.
- States: IDLE, START, DATA, PARITY (only when PARITY_EN=1), STOP.
- Launch condition L = tx_enable & !fifo_empty. It is evaluated in IDLE and in the final cycle of the last stop bit.
- fifo_read_enable is combinational and equals L in those two situations, otherwise 0. It is never asserted when fifo_empty=1.
- In the cycle where L is true:
  - fifo_data is captured into the shift register.
  - baud_div is latched as N; N=0 is treated as 1.
  - Parity is computed from the captured byte.
  - The next state is START.
- Bit timing:
  - Each bit holds tx for exactly N clocks.
  - Start bit: tx=0, beginning the cycle after the launch cycle.
  - Data: bit 0 first, bit 7 last.
  - Parity bit: XOR of the data bits, inverted when PARITY_ODD=1.
  - Stop bits: tx=1, STOP_BITS x N clocks.
  - Frame length is (1+8+PARITY_EN+STOP_BITS) x N clocks.
- End of frame:
  - The last STOP cycle asserts frame_done.
  - If L is true in that cycle, the next byte is popped and START follows immediately, giving zero idle gap.
  - Otherwise the block goes to IDLE.
- busy is 1 in START, DATA, PARITY and STOP, and 0 in IDLE. busy is registered and aligned with tx.
- tx is registered and glitch-free.
- Changes to baud_div or tx_enable during a frame do not affect that frame.
- tx_enable falling mid-frame: the current frame completes and no further pop occurs.
- FIFO becoming empty mid-frame has no effect; the byte is already captured.
- Counters:
  - 16-bit baud counter counts 0 to N-1.
  - 4-bit bit index.
  - No wrap hazards for N up to 65535.

Test Plan:
- Single byte: PARITY_EN=0, STOP_BITS=1, baud_div=4, FIFO holds 0x55, tx_enable=1.
  - Exactly one fifo_read_enable pulse.
  - tx reads 0 (4 clk), then 1,0,1,0,1,0,1,0 (4 clk each), then 1 (4 clk).
  - frame_done pulses once at clock 40 after launch.
  - busy is high for 40 clocks.
- Back-to-back: FIFO holds 0xA3, 0x0F, baud_div=2.
  - Two pops spaced 20 clocks apart.
  - The second start bit begins the cycle after the first frame_done, with no idle cycle.
  - Both bytes are decoded correctly by the bench's serial monitor.
- Parity: PARITY_EN=1, PARITY_ODD=0, byte 0x07, baud_div=3 → parity bit 1.
  - Same with PARITY_ODD=1 → parity bit 0.
  - Frame length 33 clocks.
- STOP_BITS=2, byte 0xFF, baud_div=1 → 11-clock frame; tx low only during the start bit.
- Flow control:
  - fifo_empty=1 with tx_enable=1 → no pop, tx stays 1, busy stays 0.
  - tx_enable dropped mid-frame with FIFO non-empty → frame finishes, no further pop.
  - baud_div=0 behaves as 1.
- Reset mid-frame: reset_n=0 during DATA bit 3 → next edge gives tx=1, busy=0, no frame_done; after release, the next FIFO byte transmits normally.
